// File: rtl/loop_filter_pkg.sv
// loop_filter_pkg: shared defaults, FSM states and saturating add for loop_filter_sched
package loop_filter_pkg;
  localparam int DEF_NCH = 4;
  localparam int DEF_W = 28;
  localparam int DEF_KI_SHIFT = 13;
  localparam int DEF_KP_SHIFT = 22;
  typedef enum logic [1:0] {IDLE, INTEG, PROP, OUT} state_t;
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a, input logic signed [63:0] b, input int w);
    logic signed [63:0] s, hi, lo;
    s = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return s > hi ? hi : s < lo ? lo : s;
  endfunction
endpackage

// File: rtl/loop_filter_sched_rr_arbiter.sv
// rr_arbiter: round-robin pick of the first request after the last granted channel
module rr_arbiter #(
  parameter int NCH = 4,
  localparam int CW = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [CW-1:0]  last,
  output logic [NCH-1:0] gnt,
  output logic [CW-1:0]  idx
);
  logic [CW-1:0] c;
  logic hit;
  always_comb begin
    idx = '0;
    hit = 1'b0;
    c = '0;
    for (int k = 1; k <= NCH; k++) begin
      c = last + CW'(k);
      if (!hit && req[c]) begin
        hit = 1'b1;
        idx = c;
      end
    end
    gnt = hit ? NCH'(1) << idx : '0;
  end
endmodule

// File: rtl/loop_filter_sched.sv
// loop_filter_sched: shared PI datapath time-multiplexed over NCH channels
module loop_filter_sched import loop_filter_pkg::*; #(
  parameter int NCH = DEF_NCH,
  parameter int W = DEF_W,
  parameter int KI_SHIFT = DEF_KI_SHIFT,
  parameter int KP_SHIFT = DEF_KP_SHIFT,
  localparam int CW = $clog2(NCH)
) (
  input  logic                clk_sys,
  input  logic                rst,
  input  logic [NCH-1:0]      req_valid,
  input  logic [NCH*W-1:0]    req_err,
  output logic [NCH-1:0]      req_ready,
  input  logic [NCH-1:0]      clr_ch,
  output logic                out_valid,
  output logic [CW-1:0]       out_ch,
  output logic signed [W-1:0] out_ctrl,
  output logic                busy
);
  state_t state, state_nx;
  logic [CW-1:0] last, g, gi, och;
  logic [NCH-1:0] gnt;
  logic signed [W-1:0] acc [NCH];
  logic signed [W-1:0] errs [NCH];
  logic signed [W-1:0] err, ctrl, acc_nx, ctrl_nx;
  rr_arbiter #(.NCH(NCH)) u_arb (.req(req_valid), .last(last), .gnt(gnt), .idx(gi));
  always_comb begin
    for (int i = 0; i < NCH; i++) errs[i] = req_err[i*W +: W];
    state_nx = state == IDLE ? (|req_valid ? INTEG : IDLE) : state == INTEG ? PROP : state == PROP ? OUT : IDLE;
    acc_nx = W'(sat_add(64'(acc[g]), 64'(err) >>> KI_SHIFT, W));
    ctrl_nx = W'(sat_add(64'(acc[g]), 64'(err) >>> KP_SHIFT, W));
    req_ready = !rst && state == IDLE ? gnt : '0;
    out_valid = !rst && state == OUT;
    busy = !rst && state != IDLE;
    out_ch = rst ? '0 : och;
    out_ctrl = rst ? '0 : ctrl;
  end
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state <= IDLE;
      last <= CW'(NCH - 1);
      g <= '0;
      err <= '0;
      och <= '0;
      ctrl <= '0;
      for (int i = 0; i < NCH; i++) acc[i] <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && |req_valid) begin
        g <= gi;
        last <= gi;
        err <= errs[gi];
      end
      if (state == PROP) begin
        och <= g;
        ctrl <= ctrl_nx;
      end
      for (int i = 0; i < NCH; i++)
        if (clr_ch[i]) acc[i] <= '0;
        else if (state == INTEG && g == CW'(i)) acc[i] <= acc_nx;
    end
  end
endmodule
